// File: rtl/fetch_pc_unit.sv
// Fetch-stage next-PC generator: PC register, direct-mapped BTB, redirect on
// EX mispredict, predictor training port and saturating event counters.
module fetch_pc_unit #(
  parameter int unsigned BTB_SIZE_LOG2 = 4,
  parameter logic [31:0] RESET_PC      = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        prediction,
  output logic [31:0] pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        flush,
  output logic        update_enable,
  output logic [31:0] update_pc,
  output logic        actual_taken,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int unsigned IDX_W   = BTB_SIZE_LOG2;
  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned TAG_W   = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]   btb_tag    [ENTRIES];
  logic [31:0]        btb_target [ENTRIES];
  logic               btb_jump   [ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             hit;
  logic [31:0]      pc_plus4;
  logic             ctl;
  logic             mispredict;
  logic             btb_write;
  logic [31:0]      next_pc;

  // BTB lookup, prediction and mispredict detection
  always_comb begin
    rd_idx      = pc[IDX_W+1:2];
    rd_tag      = pc[31:IDX_W+2];
    wr_idx      = ex_pc[IDX_W+1:2];
    hit         = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
    pred_taken  = hit && (btb_jump[rd_idx] || prediction);
    pc_plus4    = pc + 32'd4;
    pred_target = pred_taken ? btb_target[rd_idx] : pc_plus4;
    ctl         = ex_valid && (ex_is_branch || ex_is_jump);
    mispredict  = ctl && ((ex_taken != ex_pred_taken) ||
                          (ex_taken && (ex_target != ex_pred_target)));
    flush       = mispredict && rst;
    btb_write   = ctl && ex_taken;
    if (mispredict) begin
      next_pc = ex_taken ? ex_target : (ex_pc + 32'd4);
    end else if (stall) begin
      next_pc = pc;
    end else begin
      next_pc = pred_target;
    end
  end

  // Control state: pc, BTB valid bits, predictor update, counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc               <= RESET_PC;
      btb_valid        <= '0;
      update_enable    <= 1'b0;
      update_pc        <= 32'h0;
      actual_taken     <= 1'b0;
      branch_count     <= 32'h0;
      mispredict_count <= 32'h0;
    end else begin
      pc            <= next_pc;
      update_enable <= ctl && ex_is_branch && !ex_is_jump;
      update_pc     <= ex_pc;
      actual_taken  <= ex_taken;
      if (btb_write) begin
        btb_valid[wr_idx] <= 1'b1;
      end
      if (ctl && (branch_count != 32'hFFFF_FFFF)) begin
        branch_count <= branch_count + 32'd1;
      end
      if (mispredict && (mispredict_count != 32'hFFFF_FFFF)) begin
        mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

  // BTB payload; only meaningful behind a valid bit, so no reset needed
  always_ff @(posedge clk) begin
    if (rst && btb_write) begin
      btb_tag[wr_idx]    <= ex_pc[31:IDX_W+2];
      btb_target[wr_idx] <= ex_target;
      btb_jump[wr_idx]   <= ex_is_jump;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vectors, a keyed-by-PC BTB model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int unsigned ENTRIES  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        prediction;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jump;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        flush;
  logic        update_enable;
  logic [31:0] update_pc;
  logic        actual_taken;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  fetch_pc_unit #(.BTB_SIZE_LOG2(4), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .prediction(prediction),
    .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .flush(flush), .update_enable(update_enable), .update_pc(update_pc),
    .actual_taken(actual_taken), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: BTB as a map from trained branch PC to its target/kind
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_tgt [logic [31:0]];
  logic        m_jmp [logic [31:0]];
  logic        m_ue = 1'b0;
  logic [31:0] m_upc = 32'h0;
  logic        m_at = 1'b0;
  logic [31:0] m_bc = 32'h0;
  logic [31:0] m_mc = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned bidx(input logic [31:0] a);
    return (a / 4) % ENTRIES;
  endfunction

  task automatic model_pred(output logic pt, output logic [31:0] ptg);
    logic hit;
    hit = m_tgt.exists(m_pc);
    pt  = hit && (m_jmp[m_pc] || prediction);
    ptg = pt ? m_tgt[m_pc] : m_pc + 32'd4;
  endtask

  function automatic logic model_ctl();
    return ex_valid && (ex_is_branch || ex_is_jump);
  endfunction

  function automatic logic model_mp();
    if (!model_ctl()) return 1'b0;
    if (ex_taken != ex_pred_taken) return 1'b1;
    return ex_taken && (ex_target != ex_pred_target);
  endfunction

  // Model advance on each clock edge
  always @(posedge clk) begin
    logic pt;
    logic [31:0] ptg;
    logic [31:0] victims [$];
    logic ctl, mp;
    model_pred(pt, ptg);
    ctl = model_ctl();
    mp  = model_mp();
    if (!rst) begin
      m_pc = RESET_PC;
      m_tgt.delete();
      m_jmp.delete();
      m_ue = 1'b0; m_upc = 32'h0; m_at = 1'b0; m_bc = 32'h0; m_mc = 32'h0;
    end else begin
      if (mp) m_pc = ex_taken ? ex_target : ex_pc + 32'd4;
      else if (!stall) m_pc = ptg;
      if (ctl && ex_taken) begin
        foreach (m_tgt[k]) if (bidx(k) == bidx(ex_pc)) victims.push_back(k);
        foreach (victims[i]) begin
          m_tgt.delete(victims[i]);
          m_jmp.delete(victims[i]);
        end
        m_tgt[ex_pc] = ex_target;
        m_jmp[ex_pc] = ex_is_jump;
      end
      m_ue  = ctl && ex_is_branch && !ex_is_jump;
      m_upc = ex_pc;
      m_at  = ex_taken;
      if (ctl && m_bc < 32'hFFFF_FFFF) m_bc = m_bc + 32'd1;
      if (mp && m_mc < 32'hFFFF_FFFF) m_mc = m_mc + 32'd1;
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    logic pt;
    logic [31:0] ptg;
    if (chk_en) begin
      model_pred(pt, ptg);
      chk("pc", pc, m_pc);
      chk("pred_taken", 32'(pred_taken), 32'(pt));
      chk("pred_target", pred_target, ptg);
      chk("flush", 32'(flush), 32'(model_mp() && rst));
      chk("update_enable", 32'(update_enable), 32'(m_ue));
      chk("update_pc", update_pc, m_upc);
      chk("actual_taken", 32'(actual_taken), 32'(m_at));
      chk("branch_count", branch_count, m_bc);
      chk("mispredict_count", mispredict_count, m_mc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic ex_drive(input logic br, input logic jmp, input logic [31:0] epc,
                          input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
    ex_valid = 1'b1; ex_is_branch = br; ex_is_jump = jmp; ex_pc = epc;
    ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  task automatic ex_clear();
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_pc = 32'h0;
    ex_taken = 1'b0; ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
  endtask

  // Redirect fetch to addr via a not-taken branch that was predicted taken
  task automatic redirect(input logic [31:0] addr);
    ex_drive(1'b1, 1'b0, addr - 32'd4, 1'b0, 32'h0, 1'b1, 32'h0);
    step();
    ex_clear();
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; prediction = 1'b0;
    ex_clear();
    step();
    step();
    chk_en = 1'b1;
    rst = 1'b1;
    settle();
    chk("t1 reset pc", pc, 32'h0);
    chk("t1 reset pred_target", pred_target, 32'h4);
    chk("t1 reset pred_taken", 32'(pred_taken), 32'h0);
    chk("t1 reset counters", branch_count | mispredict_count, 32'h0);
    step(); settle(); chk("t1 pc4", pc, 32'h4);
    step(); settle(); chk("t1 pc8", pc, 32'h8);
    step(); settle(); chk("t1 pcC", pc, 32'hC);

    // Mispredicted taken branch @0x10 -> 0x40
    ex_drive(1'b1, 1'b0, 32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
    settle();
    chk("t2 flush", 32'(flush), 32'h1);
    step();
    ex_clear();
    settle();
    chk("t2 pc", pc, 32'h40);
    chk("t2 update_enable", 32'(update_enable), 32'h1);
    chk("t2 update_pc", update_pc, 32'h10);
    chk("t2 actual_taken", 32'(actual_taken), 32'h1);
    chk("t2 mispredict_count", mispredict_count, 32'h1);
    chk("t2 branch_count", branch_count, 32'h1);
    step(); settle();
    chk("t2 update pulse ends", 32'(update_enable), 32'h0);
    chk("t2 pc44", pc, 32'h44);

    // Refetch 0x10: predictor decides
    redirect(32'h10);
    prediction = 1'b1;
    settle();
    chk("t3 pred_taken", 32'(pred_taken), 32'h1);
    chk("t3 pred_target", pred_target, 32'h40);
    step(); settle();
    chk("t3 pc40", pc, 32'h40);
    redirect(32'h10);
    prediction = 1'b0;
    settle();
    chk("t3 not taken", 32'(pred_taken), 32'h0);
    step(); settle();
    chk("t3 pc14", pc, 32'h14);

    // JAL @0x20 -> 0x80 trains BTB as a jump
    ex_drive(1'b0, 1'b1, 32'h20, 1'b1, 32'h80, 1'b0, 32'h24);
    step();
    ex_clear();
    settle();
    chk("t4 pc80", pc, 32'h80);
    chk("t4 no update", 32'(update_enable), 32'h0);
    redirect(32'h20);
    prediction = 1'b0;
    settle();
    chk("t4 jump pred_taken", 32'(pred_taken), 32'h1);
    chk("t4 jump pred_target", pred_target, 32'h80);
    step(); settle();
    chk("t4 pc80 again", pc, 32'h80);

    // Mispredict overrides stall, then stall holds
    stall = 1'b1;
    ex_drive(1'b1, 1'b0, 32'h30, 1'b0, 32'h0, 1'b1, 32'h90);
    step();
    ex_clear();
    settle();
    chk("t5 pc34", pc, 32'h34);
    step(); settle();
    chk("t5 stall hold", pc, 32'h34);
    stall = 1'b0;

    // Correctly predicted not-taken branch, and branch+jump treated as jump
    ex_drive(1'b1, 1'b0, 32'h50, 1'b0, 32'h0, 1'b0, 32'h54);
    settle();
    chk("t5 correct no flush", 32'(flush), 32'h0);
    step();
    ex_drive(1'b1, 1'b1, 32'h60, 1'b1, 32'h90, 1'b1, 32'h90);
    step();
    ex_clear();
    settle();
    chk("t5 both flags no update", 32'(update_enable), 32'h0);
    redirect(32'h60);
    settle();
    chk("t5 both flags jump hit", pred_target, 32'h90);
    step();

    // Aliasing: 0x410 shares index with 0x10 but has another tag
    redirect(32'h410);
    prediction = 1'b1;
    settle();
    chk("t6 alias miss", 32'(pred_taken), 32'h0);
    chk("t6 alias target", pred_target, 32'h414);
    step();

    // Address wrap
    redirect(32'hFFFF_FFFC);
    prediction = 1'b0;
    settle();
    chk("t6 wrap target", pred_target, 32'h0);
    step(); settle();
    chk("t6 wrap pc", pc, 32'h0);

    // Reset mid-run beats concurrent mispredict and BTB write
    rst = 1'b0;
    stall = 1'b1;
    ex_drive(1'b1, 1'b0, 32'h70, 1'b1, 32'hA0, 1'b0, 32'h74);
    settle();
    chk("t6 flush gated by reset", 32'(flush), 32'h0);
    step();
    rst = 1'b1;
    stall = 1'b0;
    ex_clear();
    settle();
    chk("t6 reset pc", pc, RESET_PC);
    chk("t6 reset counters", branch_count | mispredict_count, 32'h0);
    redirect(32'h10);
    prediction = 1'b1;
    settle();
    chk("t6 btb cleared", 32'(pred_taken), 32'h0);
    redirect(32'h70);
    settle();
    chk("t6 reset blocked write", 32'(pred_taken), 32'h0);
    step();
    step();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
